// File: rtl/pio_input_capture.sv
// Parallel input port with edge capture, per-bit interrupt mask and level irq.
// Define PIO_DEBOUNCE_EN to add per-bit debounce counters after the synchronizer.
module pio_input_capture #(
   parameter int DATA_WIDTH      = 10,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] sync2;
   logic [DATA_WIDTH-1:0] stable;
   logic [DATA_WIDTH-1:0] prev;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] edgecapture;
   logic [DATA_WIDTH-1:0] irqmask;
   logic [DATA_WIDTH-1:0] clear_bits;
   logic [DATA_WIDTH-1:0] wdata;
   logic [31:0]           read_mux;
   logic                  wr_en;
   logic                  unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[DATA_WIDTH-1:0];
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   logic [7:0] db_count [DATA_WIDTH];

   // A bit flips only after s2 has disagreed with it for DEBOUNCE_CYCLES clocks in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= '0;
         for (int i = 0; i < DATA_WIDTH; i++) db_count[i] <= '0;
      end else begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (sync2[i] != stable[i]) begin
               if (db_count[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                  stable[i]   <= sync2[i];
                  db_count[i] <= '0;
               end else begin
                  db_count[i] <= db_count[i] + 8'd1;
               end
            end else begin
               db_count[i] <= '0;
            end
         end
      end
   end
`else
   assign stable = sync2;
`endif

   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         0:       edge_det = stable & ~prev;
         1:       edge_det = ~stable & prev;
         default: edge_det = stable ^ prev;
      endcase
   end

   assign clear_bits = (wr_en && address == 2'd3) ? wdata : '0;

   // New edges are OR-ed in after the clear, so a same-cycle edge survives its clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev        <= '0;
         edgecapture <= '0;
         irqmask     <= '0;
      end else begin
         prev        <= stable;
         edgecapture <= (edgecapture & ~clear_bits) | edge_det;
         if (wr_en && address == 2'd2) irqmask <= wdata;
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         2'd0:    read_mux = 32'(stable);
         2'd2:    read_mux = 32'(irqmask);
         2'd3:    read_mux = 32'(edgecapture);
         default: read_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) readdata <= '0;
      else       readdata <= read_mux;
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_input_capture.sv
// Self-checking bench for pio_input_capture: rising, falling and any-edge instances share one bus.
module tb_pio_input_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [9:0]  in_port;
   logic [31:0] rd_rise, rd_fall, rd_any;
   logic        irq_rise, irq_fall, irq_any;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pio_input_capture #(.DATA_WIDTH(10), .EDGE_TYPE(0)) dut_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_rise), .irq(irq_rise));

   pio_input_capture #(.DATA_WIDTH(10), .EDGE_TYPE(1)) dut_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_fall), .irq(irq_fall));

   pio_input_capture #(.DATA_WIDTH(10), .EDGE_TYPE(2)) dut_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd_any), .irq(irq_any));

   typedef struct {
      logic [9:0]  pins;
      logic [1:0]  addr;
      logic        cs;
      logic        wn;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [26];

   // Drive one cycle's inputs from a falling edge and return at the next falling edge.
   task automatic applyStimulus(input logic [9:0] pins, input logic [1:0] addr,
                                input logic cs, input logic wn, input logic [31:0] wdata);
      in_port    = pins;
      address    = addr;
      chipselect = cs;
      write_n    = wn;
      writedata  = wdata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input logic [9:0] pins, input logic [1:0] addr, input int n);
      for (int i = 0; i < n; i++) applyStimulus(pins, addr, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic applyReset(input logic [9:0] pins);
      reset = 1'b1;
      applyStimulus(pins, 2'd0, 1'b0, 1'b1, 32'h0);
      applyStimulus(pins, 2'd0, 1'b0, 1'b1, 32'h0);
      reset = 1'b0;
   endtask

`ifdef PIO_DEBOUNCE_EN
   task automatic runDebounce();
      applyReset(10'h000);
      checkOutput("db_reset_rd", rd_rise, 32'h0);
      idle(10'h002, 2'd0, 3);
      idle(10'h000, 2'd0, 8);
      checkOutput("db_glitch_data", rd_rise, 32'h0);
      idle(10'h000, 2'd3, 1);
      checkOutput("db_glitch_ec", rd_rise, 32'h0);
      idle(10'h002, 2'd0, 6);
      checkOutput("db_pulse_early", rd_rise, 32'h0);
      idle(10'h000, 2'd0, 1);
      checkOutput("db_pulse_data", rd_rise, 32'h2);
      idle(10'h000, 2'd3, 1);
      checkOutput("db_pulse_ec", rd_rise, 32'h2);
      idle(10'h008, 2'd3, 3);
      reset = 1'b1;
      idle(10'h008, 2'd3, 1);
      reset = 1'b0;
      checkOutput("db_midreset_rd", rd_rise, 32'h0);
      checkOutput("db_midreset_irq", 32'(irq_rise), 32'h0);
      idle(10'h008, 2'd3, 7);
      checkOutput("db_relaunch_early", rd_rise, 32'h0);
      idle(10'h008, 2'd3, 1);
      checkOutput("db_relaunch_ec", rd_rise, 32'h8);
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{10'h000, 2'd0, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[1]  = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[2]  = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[3]  = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FF, 1'b0};
      vecs[4]  = '{10'h3FF, 2'd3, 1'b0, 1'b1, 32'h0,        32'h3FF, 1'b0};
      vecs[5]  = '{10'h3FF, 2'd3, 1'b1, 1'b0, 32'h3FF,      32'h3FF, 1'b0};
      vecs[6]  = '{10'h3FF, 2'd3, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[7]  = '{10'h3FF, 2'd2, 1'b1, 1'b0, 32'h001,      32'h000, 1'b0};
      vecs[8]  = '{10'h3FF, 2'd2, 1'b0, 1'b1, 32'h0,        32'h001, 1'b0};
      vecs[9]  = '{10'h3FE, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FF, 1'b0};
      vecs[10] = '{10'h3FE, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FF, 1'b0};
      vecs[11] = '{10'h3FE, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FE, 1'b0};
      vecs[12] = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FE, 1'b0};
      vecs[13] = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FE, 1'b0};
      vecs[14] = '{10'h3FF, 2'd0, 1'b0, 1'b1, 32'h0,        32'h3FF, 1'b1};
      vecs[15] = '{10'h3FF, 2'd3, 1'b1, 1'b0, 32'h001,      32'h001, 1'b0};
      vecs[16] = '{10'h3FF, 2'd3, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[17] = '{10'h3FE, 2'd3, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[18] = '{10'h3FE, 2'd3, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[19] = '{10'h3FE, 2'd3, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[20] = '{10'h3FE, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h000, 1'b0};
      vecs[21] = '{10'h3FE, 2'd1, 1'b0, 1'b1, 32'h0,        32'h000, 1'b0};
      vecs[22] = '{10'h3FE, 2'd2, 1'b1, 1'b0, 32'hFFFFFC02, 32'h001, 1'b0};
      vecs[23] = '{10'h3FE, 2'd2, 1'b0, 1'b1, 32'h0,        32'h002, 1'b0};
      vecs[24] = '{10'h3FE, 2'd2, 1'b0, 1'b0, 32'h3FF,      32'h002, 1'b0};
      vecs[25] = '{10'h3FE, 2'd2, 1'b0, 1'b1, 32'h0,        32'h002, 1'b0};

      reset = 1'b1;
      in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      @(negedge clk);

`ifdef PIO_DEBOUNCE_EN
      runDebounce();
`else
      applyReset(10'h000);
      checkOutput("reset_rd", rd_rise, 32'h0);
      checkOutput("reset_irq", 32'(irq_rise), 32'h0);

      for (int i = 0; i < 26; i++) begin
         applyStimulus(vecs[i].pins, vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wdata);
         checkOutput($sformatf("vec%0d_rd", i), rd_rise, vecs[i].exp_rd);
         checkOutput($sformatf("vec%0d_irq", i), 32'(irq_rise), 32'(vecs[i].exp_irq));
      end

      // Edge on bit 2 lands in the same cycle as its write-1-to-clear.
      idle(10'h3FA, 2'd3, 3);
      idle(10'h3FE, 2'd3, 2);
      applyStimulus(10'h3FE, 2'd3, 1'b1, 1'b0, 32'h004);
      idle(10'h3FE, 2'd3, 1);
      checkOutput("setwins_ec", rd_rise, 32'h004);
      checkOutput("setwins_irq", 32'(irq_rise), 32'h0);
      applyStimulus(10'h3FE, 2'd2, 1'b1, 1'b0, 32'h004);
      checkOutput("mask_irq", 32'(irq_rise), 32'h1);
      checkOutput("mask_old_rd", rd_rise, 32'h002);

      // Reset beats a simultaneous mask write and drops irq at once.
      reset = 1'b1;
      applyStimulus(10'h008, 2'd2, 1'b1, 1'b0, 32'h3FF);
      reset = 1'b0;
      checkOutput("rst_rd", rd_rise, 32'h0);
      checkOutput("rst_irq", 32'(irq_rise), 32'h0);
      idle(10'h008, 2'd2, 1);
      checkOutput("rst_mask", rd_rise, 32'h0);
      idle(10'h008, 2'd3, 2);
      checkOutput("rel_early", rd_rise, 32'h0);
      idle(10'h008, 2'd3, 1);
      checkOutput("rel_rise_ec", rd_rise, 32'h008);
      checkOutput("rel_fall_ec", rd_fall, 32'h000);
      checkOutput("rel_any_ec", rd_any, 32'h008);

      idle(10'h018, 2'd3, 4);
      checkOutput("b4up_fall", rd_fall, 32'h000);
      checkOutput("b4up_any", rd_any, 32'h018);
      idle(10'h008, 2'd3, 4);
      checkOutput("b4dn_fall", rd_fall, 32'h010);
      checkOutput("b4dn_any", rd_any, 32'h018);
      idle(10'h018, 2'd3, 4);
      checkOutput("b4up2_fall", rd_fall, 32'h010);
      checkOutput("b4up2_rise", rd_rise, 32'h018);
      applyStimulus(10'h018, 2'd2, 1'b1, 1'b0, 32'h010);
      checkOutput("fall_irq_on", 32'(irq_fall), 32'h1);
      applyStimulus(10'h018, 2'd3, 1'b1, 1'b0, 32'h010);
      checkOutput("fall_irq_off", 32'(irq_fall), 32'h0);
      checkOutput("rise_irq_off", 32'(irq_rise), 32'h0);
      checkOutput("any_irq_off", 32'(irq_any), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pio_input_capture.md
PIO_INPUT_CAPTURE -- requirements
Module: pio_input_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 10, number of input pins, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, debounce qualification length in clocks, legal range 1..255; used only when PIO_DEBOUNCE_EN is defined.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  2  register select.
REQ-007 chipselect  input  1  slave select, active-high.
REQ-008 write_n  input  1  write strobe, active-low, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  DATA_WIDTH  asynchronous external pins.
REQ-011 readdata  output  32  registered read data, zero-extended.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 in_port SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Register map: addr 0 = data (read-only), addr 1 = reserved (reads 0, writes ignored), addr 2 = irqmask (R/W, DATA_WIDTH bits), addr 3 = edgecapture (read, write-1-to-clear).
REQ-015 readdata SHALL update every clock from the register selected by address, regardless of chipselect; one-cycle read latency; bits [31:DATA_WIDTH] always 0.
REQ-016 A write occurs when chipselect=1 and write_n=0; only writedata[DATA_WIDTH-1:0] is used.
REQ-017 Stable value = s2 (without debounce); prev register holds stable delayed one clock.
REQ-018 Edge per bit: rising = stable & ~prev; falling = ~stable & prev; any = stable ^ prev.
REQ-019 edgecapture bit SHALL set on the clock after its edge is detected and hold until cleared.
REQ-020 Write of 1 to addr 3 bit clears that bit; 0 bits unaffected.
REQ-021 Same-cycle edge and clear on one bit: set wins, bit stays 1.
REQ-022 irq = OR over bits of (edgecapture & irqmask), driven from registers, no extra cycle.
REQ-023 Writing irqmask takes effect on irq the clock after the write.
REQ-024 Latency, no debounce: in_port change before edge e1 -> data visible on readdata and edgecapture/irq set after edge e3.
REQ-025 Multiple edges on a bit before clearing SHALL leave a single set bit; no counting.

Reset
REQ-026 With reset=1 at a rising edge: readdata, irqmask, edgecapture, s1, s2, prev, and all debounce state -> 0; irq -> 0 the same cycle.
REQ-027 Reset mid-operation SHALL discard pending edges and debounce counts; when reset releases with in_port high, a rising edge SHALL be captured.
REQ-028 Reset SHALL take priority over simultaneous writes.

Configuration
REQ-029 Macro PIO_DEBOUNCE_EN: when defined, each bit has a counter; stable bit toggles only after s2 differs from stable for DEBOUNCE_CYCLES consecutive clocks; any cycle with s2 == stable zeroes the counter.
REQ-030 With PIO_DEBOUNCE_EN, REQ-024 latency grows by DEBOUNCE_CYCLES clocks; without it, no counters are instantiated and stable = s2.

Verification
REQ-031 Reset, then in_port=10'h3FF held; read addr 0 -> readdata=32'h000003FF; edgecapture=0x3FF; irq=0 with irqmask=0.
REQ-032 Write irqmask=0x001, then pulse in_port[0] 0->1 -> irq=1 three clocks after the change; write 0x001 to addr 3 -> irq=0 next clock.
REQ-033 EDGE_TYPE=1: in_port[4] 1->0 -> edgecapture=0x010; in_port[4] 0->1 -> no new bit set.
REQ-034 Same-cycle edge on bit 2 and write 0x004 to addr 3 -> edgecapture bit 2 remains 1.
REQ-035 PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-clock glitch on in_port[1] -> no data change, no capture; 6-clock pulse -> captured, data updates 4 clocks later than the non-debounced build.
REQ-036 Assert reset for 1 clock mid-debounce with in_port[3]=1 -> all registers 0; after release, bit 3 edge captured after full latency.
